mem_access_stage: RTL and testbench

//  MEM-stage consumer of the EX/MEM latch: owns the data memory and executes stores and loads.
//  - Stores: size-filtered and byte-lane merged. Loads: size-filtered, then sign- or zero-extended.
//  - Resolves the branch decision from EX/MEM control bits.
//  - A debug-dump FSM streams the whole data memory out over a valid/ready port.

---
 rtl/mips_mem_pkg.sv | 32 +++
 rtl/mem_load_filter.sv | 35 +++
 rtl/mem_access_stage.sv | 135 +++++++++++++
 tb/tb_mem_access_stage.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, dump FSM states and lane helpers.
// Optional feature macro used by the stage: MEM_MISALIGN_TRAP_EN.
package mips_mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef logic [1:0] dump_state_t;

  localparam dump_state_t DUMP_IDLE = 2'd0;
  localparam dump_state_t DUMP_RUN  = 2'd1;
  localparam dump_state_t DUMP_DONE = 2'd2;

  // Natural-alignment lane for an access; encoding 2'b11 behaves as a word.
  function automatic logic [1:0] align_lane(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: return lane;
      SIZE_HALF: return {lane[1], 1'b0};
      default:   return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return lane[0];
      default:   return |lane;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_filter.sv
// Combinational load path: picks the addressed byte/half/word and sign- or zero-extends it.
// The lane input is expected to be already aligned to the access size.
module mem_load_filter
  import mips_mem_pkg::*;
#(
  parameter int BITS_SIZE = 32
) (
  input  logic [BITS_SIZE-1:0] word,
  input  logic [1:0]           lane,
  input  logic [1:0]           size,
  input  logic                 zero_extend,
  input  logic                 enable,
  output logic [BITS_SIZE-1:0] data
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  assign byte_val = word[{lane, 3'b000} +: 8];
  assign half_val = word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    data = '0;
    if (enable) begin
      case (size)
        SIZE_BYTE: data = zero_extend ? BITS_SIZE'(byte_val)
                                      : {{(BITS_SIZE-8){byte_val[7]}}, byte_val};
        SIZE_HALF: data = zero_extend ? BITS_SIZE'(half_val)
                                      : {{(BITS_SIZE-16){half_val[15]}}, half_val};
        default:   data = word;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data memory with byte-lane stores, filtered loads, branch resolve and a memory dump port.
// Define MEM_MISALIGN_TRAP_EN to flag and suppress misaligned accesses instead of force-aligning them.
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter  int BITS_SIZE = 32,
  parameter  int MEM_DEPTH = 64,
  localparam int ADDR_BITS = $clog2(MEM_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_step,
  input  logic [BITS_SIZE-1:0] i_alu,
  input  logic [BITS_SIZE-1:0] i_register_2,
  input  logic                 i_mem_write,
  input  logic                 i_mem_read,
  input  logic [1:0]           i_size_filter,
  input  logic [1:0]           i_size_filterL,
  input  logic                 i_zero_extend,
  input  logic                 i_branch,
  input  logic                 i_new_branch,
  input  logic                 i_zero,
  output logic [BITS_SIZE-1:0] o_read_data,
  output logic                 o_pc_src,
  input  logic                 i_dump_start,
  input  logic                 i_dump_ready,
  output logic                 o_dump_valid,
  output logic [ADDR_BITS-1:0] o_dump_addr,
  output logic [BITS_SIZE-1:0] o_dump_data,
  output logic                 o_dump_busy,
  output logic                 o_dump_done
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                 o_misaligned
`endif
);

  logic [BITS_SIZE-1:0] mem [MEM_DEPTH];

  logic [ADDR_BITS-1:0] word_idx;
  logic [1:0]           raw_lane;
  logic [1:0]           store_lane;
  logic [1:0]           load_lane;
  logic                 store_bad;
  logic                 load_bad;
  logic                 store_en;
  logic [BITS_SIZE-1:0] cur_word;
  logic [BITS_SIZE-1:0] merged;
  logic                 unused_alu;

  dump_state_t          state;
  logic [ADDR_BITS-1:0] dump_idx;

  // Upper address bits wrap onto the array.
  assign word_idx   = i_alu[ADDR_BITS+1:2];
  assign raw_lane   = i_alu[1:0];
  assign unused_alu = ^i_alu[BITS_SIZE-1:ADDR_BITS+2];
  assign store_lane = align_lane(i_size_filter, raw_lane);
  assign load_lane  = align_lane(i_size_filterL, raw_lane);

`ifdef MEM_MISALIGN_TRAP_EN
  assign store_bad    = is_misaligned(i_size_filter, raw_lane);
  assign load_bad     = is_misaligned(i_size_filterL, raw_lane);
  assign o_misaligned = (i_mem_write & store_bad) | (i_mem_read & load_bad);
`else
  assign store_bad = 1'b0;
  assign load_bad  = 1'b0;
`endif

  assign cur_word = mem[word_idx];

  always_comb begin
    merged = cur_word;
    case (i_size_filter)
      SIZE_BYTE: merged[{store_lane, 3'b000} +: 8]      = i_register_2[7:0];
      SIZE_HALF: merged[{store_lane[1], 4'b0000} +: 16] = i_register_2[15:0];
      default:   merged = i_register_2;
    endcase
  end

  // Stores are frozen for the whole dump so the streamed image is a consistent snapshot.
  assign store_en = i_step & i_mem_write & (state == DUMP_IDLE) & ~store_bad;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    end else if (store_en) begin
      mem[word_idx] <= merged;
    end
  end

  mem_load_filter #(.BITS_SIZE(BITS_SIZE)) u_load_filter (
    .word        (cur_word),
    .lane        (load_lane),
    .size        (i_size_filterL),
    .zero_extend (i_zero_extend),
    .enable      (i_mem_read & ~load_bad),
    .data        (o_read_data)
  );

  assign o_pc_src = (i_branch & i_zero) | (i_new_branch & ~i_zero);

  // Dump handshake: a word transfers on any posedge where o_dump_valid and i_dump_ready are
  // both high; while valid is high without ready, addr and data hold (memory is frozen too).
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= DUMP_IDLE;
      dump_idx <= '0;
    end else begin
      case (state)
        DUMP_IDLE: begin
          if (i_dump_start) begin
            state    <= DUMP_RUN;
            dump_idx <= '0;
          end
        end
        DUMP_RUN: begin
          if (i_dump_ready) begin
            dump_idx <= dump_idx + ADDR_BITS'(1);
            if (dump_idx == ADDR_BITS'(MEM_DEPTH - 1)) state <= DUMP_DONE;
          end
        end
        DUMP_DONE: state <= DUMP_IDLE;
        default:   state <= DUMP_IDLE;
      endcase
    end
  end

  assign o_dump_valid = (state == DUMP_RUN);
  assign o_dump_busy  = (state != DUMP_IDLE);
  assign o_dump_done  = (state == DUMP_DONE);
  assign o_dump_addr  = dump_idx;
  assign o_dump_data  = mem[dump_idx];

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage against a byte-mask memory model.
// Honours MEM_MISALIGN_TRAP_EN when defined.
module tb_mem_access_stage;

  localparam int BITS_SIZE = 32;
  localparam int MEM_DEPTH = 64;
  localparam int ADDR_BITS = 6;

  logic                 clk;
  logic                 reset;
  logic                 step;
  logic [31:0]          alu;
  logic [31:0]          reg2;
  logic                 mem_write;
  logic                 mem_read;
  logic [1:0]           size_s;
  logic [1:0]           size_l;
  logic                 zext;
  logic                 branch;
  logic                 new_branch;
  logic                 zero;
  logic [31:0]          read_data;
  logic                 pc_src;
  logic                 dump_start;
  logic                 dump_ready;
  logic                 dump_valid;
  logic [ADDR_BITS-1:0] dump_addr;
  logic [31:0]          dump_data;
  logic                 dump_busy;
  logic                 dump_done;
`ifdef MEM_MISALIGN_TRAP_EN
  logic                 misaligned;
`endif

  int tests;
  int fails;

  logic [31:0] ref_mem [MEM_DEPTH];
  logic [31:0] exp_q[$];

  mem_access_stage #(.BITS_SIZE(BITS_SIZE), .MEM_DEPTH(MEM_DEPTH)) dut (
    .i_clk          (clk),
    .i_reset        (reset),
    .i_step         (step),
    .i_alu          (alu),
    .i_register_2   (reg2),
    .i_mem_write    (mem_write),
    .i_mem_read     (mem_read),
    .i_size_filter  (size_s),
    .i_size_filterL (size_l),
    .i_zero_extend  (zext),
    .i_branch       (branch),
    .i_new_branch   (new_branch),
    .i_zero         (zero),
    .o_read_data    (read_data),
    .o_pc_src       (pc_src),
    .i_dump_start   (dump_start),
    .i_dump_ready   (dump_ready),
    .o_dump_valid   (dump_valid),
    .o_dump_addr    (dump_addr),
    .o_dump_data    (dump_data),
    .o_dump_busy    (dump_busy),
    .o_dump_done    (dump_done)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .o_misaligned   (misaligned)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int size_bytes(input logic [1:0] size);
    if (size == 2'b00) return 1;
    if (size == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int word_of(input logic [31:0] addr);
    return int'(addr[ADDR_BITS+1:2]);
  endfunction

  function automatic void model_store(input logic [31:0] addr, input logic [1:0] size,
                                      input logic [31:0] data);
    int n;
    int lane;
    int w;
    logic [31:0] low;
    logic [31:0] mask;
    n    = size_bytes(size);
    lane = int'(addr % 4);
    w    = word_of(addr);
`ifdef MEM_MISALIGN_TRAP_EN
    if (lane % n != 0) return;
`endif
    lane = lane - lane % n;
    low  = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * n)) - 32'h1);
    mask = low << (8 * lane);
    ref_mem[w] = (ref_mem[w] & ~mask) | ((data & low) << (8 * lane));
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic ze);
    int n;
    int lane;
    logic [31:0] low;
    logic [31:0] val;
    n    = size_bytes(size);
    lane = int'(addr % 4);
`ifdef MEM_MISALIGN_TRAP_EN
    if (lane % n != 0) return 32'h0;
`endif
    lane = lane - lane % n;
    val  = ref_mem[word_of(addr)] >> (8 * lane);
    if (n < 4) begin
      low = (32'h1 << (8 * n)) - 32'h1;
      val = val & low;
      if (!ze && val[8 * n - 1]) val = val | ~low;
    end
    return val;
  endfunction

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic idle_inputs();
    step = 0; alu = 0; reg2 = 0; mem_write = 0; mem_read = 0;
    size_s = 0; size_l = 0; zext = 0; branch = 0; new_branch = 0; zero = 0;
    dump_start = 0; dump_ready = 0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [1:0] size,
                          input logic [31:0] data, input logic stp);
    logic [31:0] exp;
    alu = addr; reg2 = data; size_s = size; mem_write = 1; step = stp;
    #1;
    exp = mem_read ? model_load(addr, size_l, zext) : 32'h0;
    tests++;
    if (read_data !== exp) begin
      fails++;
      $display("FAIL prestore_read addr=%h got=%h exp=%h", addr, read_data, exp);
    end
    @(posedge clk); #1;
    mem_write = 0; step = 0; mem_read = 0;
    if (stp) model_store(addr, size, data);
  endtask

  task automatic check_load(input logic [31:0] addr, input logic [1:0] size, input logic ze,
                            input logic [31:0] exp, input string name);
    alu = addr; size_l = size; zext = ze; mem_read = 1;
    #1;
    tests++;
    if (read_data !== exp) begin
      fails++;
      $display("FAIL %s addr=%h got=%h exp=%h", name, addr, read_data, exp);
    end
    mem_read = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 0;
    idle_inputs();
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({dump_valid, dump_busy, dump_done} !== 3'b000) begin
      fails++;
      $display("FAIL reset_dump_flags got=%b exp=000", {dump_valid, dump_busy, dump_done});
    end
`ifdef MEM_MISALIGN_TRAP_EN
    tests++;
    if (misaligned !== 1'b0) begin
      fails++;
      $display("FAIL reset_misaligned got=%b exp=0", misaligned);
    end
`endif
    reset = 1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++)
      check_load({$urandom_range(0, 255), 2'b00}, 2'b10, 1'b0, 32'h0, "reset_mem_zero");
  endtask

  task automatic test_store_load();
    do_store(32'd8, 2'b10, 32'hDEADBEEF, 1'b1);
    check_load(32'd8, 2'b10, 1'b0, 32'hDEADBEEF, "word_store_load");
    do_store(32'd5, 2'b00, 32'h0000_0080, 1'b1);
    check_load(32'd4, 2'b10, 1'b0, 32'h0000_8000, "byte_lane_merge");
    check_load(32'd5, 2'b00, 1'b0, 32'hFFFF_FF80, "byte_sign_ext");
    check_load(32'd5, 2'b00, 1'b1, 32'h0000_0080, "byte_zero_ext");
    do_store(32'd8, 2'b10, 32'h1122_3344, 1'b1);
    do_store(32'd10, 2'b01, 32'h0000_BEEF, 1'b1);
    check_load(32'd8, 2'b10, 1'b0, 32'hBEEF_3344, "half_lane_merge");
    check_load(32'd10, 2'b01, 1'b0, 32'hFFFF_BEEF, "half_sign_ext");
    do_store(32'd8, 2'b10, 32'h5555_5555, 1'b0);
    check_load(32'd8, 2'b10, 1'b0, 32'hBEEF_3344, "no_step_no_store");
    // address wrap: bit 8 and above are ignored
    do_store(32'h0000_0100 + 32'd12, 2'b10, 32'h0BAD_F00D, 1'b1);
    check_load(32'd12, 2'b10, 1'b0, 32'h0BAD_F00D, "addr_wrap");
`ifndef MEM_MISALIGN_TRAP_EN
    do_store(32'd12, 2'b10, 32'h0, 1'b1);
    do_store(32'd13, 2'b01, 32'h0000_A5A5, 1'b1);
    check_load(32'd12, 2'b10, 1'b0, 32'h0000_A5A5, "half_force_align");
    do_store(32'd22, 2'b10, 32'h1357_9BDF, 1'b1);
    check_load(32'd20, 2'b10, 1'b0, 32'h1357_9BDF, "word_force_align");
`endif
  endtask

  task automatic test_branch();
    logic exp;
    for (int i = 0; i < 8; i++) begin
      branch = i[2]; new_branch = i[1]; zero = i[0];
      #1;
      exp = (i[2] && i[0]) || (i[1] && !i[0]);
      tests++;
      if (pc_src !== exp) begin
        fails++;
        $display("FAIL branch b=%b nb=%b z=%b got=%b exp=%b", i[2], i[1], i[0], pc_src, exp);
      end
    end
    branch = 0; new_branch = 0; zero = 0;
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  sz;
    for (int i = 0; i < 150; i++) begin
      a  = $urandom;
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        mem_read = 1'($urandom_range(0, 1));
        size_l = 2'($urandom_range(0, 3));
        zext = 1'($urandom_range(0, 1));
        do_store(a, sz, $urandom, 1'($urandom_range(0, 3) != 0));
      end else begin
        zext = 1'($urandom_range(0, 1));
        check_load(a, sz, zext, model_load(a, sz, zext), "random_load");
      end
    end
  endtask

  task automatic test_dump();
    int  exp_idx;
    int  done_cnt;
    bit  have_stall;
    bit  finished;
    logic [ADDR_BITS-1:0] stall_addr;
    logic [31:0] stall_data;
    logic [31:0] exp;
    for (int i = 0; i < MEM_DEPTH; i++) do_store(32'(i * 4), 2'b10, $urandom, 1'b1);
    exp_q.delete();
    for (int i = 0; i < MEM_DEPTH; i++) exp_q.push_back(ref_mem[i]);
    dump_start = 1;
    @(posedge clk); #1;
    dump_start = 0;
    exp_idx = 0; done_cnt = 0; have_stall = 0; finished = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      dump_ready = (cyc % 2 == 1);
      mem_write  = (cyc == 5);
      step       = (cyc == 5);
      alu        = 32'h0; size_s = 2'b10; reg2 = 32'hCAFE_0001;
      dump_start = (cyc == 7);
      #2;
      if (dump_done) begin
        done_cnt++;
        finished = 1;
      end
      if (dump_valid) begin
        if (have_stall) begin
          tests++;
          if (dump_addr !== stall_addr || dump_data !== stall_data) begin
            fails++;
            $display("FAIL dump_stable got=%0d/%h exp=%0d/%h", dump_addr, dump_data,
                     stall_addr, stall_data);
          end
        end
        if (dump_ready) begin
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
          tests++;
          if (dump_addr !== ADDR_BITS'(exp_idx) || dump_data !== exp) begin
            fails++;
            $display("FAIL dump_word got=%0d/%h exp=%0d/%h", dump_addr, dump_data, exp_idx, exp);
          end
          exp_idx++;
          have_stall = 0;
        end else begin
          have_stall = 1;
          stall_addr = dump_addr;
          stall_data = dump_data;
        end
      end
      @(posedge clk); #1;
      if (finished) break;
    end
    idle_inputs();
    tests++;
    if (!finished || exp_idx != MEM_DEPTH || done_cnt != 1) begin
      fails++;
      $display("FAIL dump_complete got=%0d words,%0d done exp=%0d words,1 done",
               exp_idx, done_cnt, MEM_DEPTH);
    end
    tests++;
    if ({dump_done, dump_busy, dump_valid} !== 3'b000) begin
      fails++;
      $display("FAIL dump_after_done got=%b exp=000", {dump_done, dump_busy, dump_valid});
    end
    check_load(32'h0, 2'b10, 1'b0, ref_mem[0], "store_dropped_in_dump");
  endtask

  task automatic test_reset_mid_dump();
    bit hit;
    int bad;
    hit = 0;
    dump_start = 1;
    @(posedge clk); #1;
    dump_start = 0;
    dump_ready = 1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      #2;
      if (dump_valid && dump_addr == ADDR_BITS'(20)) begin
        hit = 1;
        break;
      end
      @(posedge clk); #1;
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL reach_index20 got=timeout exp=index 20");
    end
    #1;
    reset = 0;
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = 32'h0;
    #1;
    tests++;
    if ({dump_busy, dump_valid, dump_done} !== 3'b000 || dump_addr !== '0) begin
      fails++;
      $display("FAIL reset_abort got=%b addr=%0d exp=000 addr=0",
               {dump_busy, dump_valid, dump_done}, dump_addr);
    end
    @(posedge clk); #1;
    reset = 1;
    bad = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(posedge clk); #1;
      if (dump_done || dump_busy) bad++;
    end
    dump_ready = 0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL no_done_after_abort got=%0d active cycles exp=0", bad);
    end
    for (int i = 0; i < 3; i++)
      check_load({$urandom_range(0, 255), 2'b00}, 2'b10, 1'b0, 32'h0, "mem_cleared");
  endtask

`ifdef MEM_MISALIGN_TRAP_EN
  task automatic test_misaligned();
    do_store(32'd4, 2'b10, 32'h0123_4567, 1'b1);
    alu = 32'd6; size_s = 2'b10; reg2 = 32'hFFFF_FFFF; mem_write = 1; step = 1;
    #1;
    tests++;
    if (misaligned !== 1'b1) begin
      fails++;
      $display("FAIL misaligned_flag got=%b exp=1", misaligned);
    end
    @(posedge clk); #1;
    mem_write = 0; step = 0;
    #1;
    tests++;
    if (misaligned !== 1'b0) begin
      fails++;
      $display("FAIL misaligned_gated got=%b exp=0", misaligned);
    end
    check_load(32'd4, 2'b10, 1'b0, 32'h0123_4567, "misaligned_store_suppressed");
    check_load(32'd5, 2'b01, 1'b0, 32'h0, "misaligned_load_zero");
  endtask
`endif

  // ---------------- main ----------------
  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_store_load();
    test_branch();
    test_random();
    test_dump();
    test_reset_mid_dump();
`ifdef MEM_MISALIGN_TRAP_EN
    test_misaligned();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
